fir_coeff_sequencer: RTL and testbench

Control block in front of the adaptive-coefficient FIR. It owns a shadow bank of NUM_TAPS signed coefficients written by a simple config port. On commit it stalls the sample stream and replays the bank onto the FIR's shared data bus with the FIR's set-coeffs strobe asserted, one tap per cycle. Outside a load it passes samples from the upstream stream to the FIR with one register stage.

---
 rtl/fir_coeff_sequencer_pkg.sv | 7 +
 rtl/fir_coeff_bank.sv | 26 ++
 rtl/fir_coeff_sequencer.sv | 63 ++++++
 tb/tb_fir_coeff_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_coeff_sequencer_pkg.sv
// fir_coeff_sequencer_pkg: shared state encoding, default sizes and address width for the FIR coefficient sequencer
package fir_coeff_sequencer_pkg;
  localparam int NUM_TAPS_DEF = 3;
  localparam int DATA_W_DEF = 6;
  localparam int ADDR_W = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, LOAD = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/fir_coeff_bank.sv
// fir_coeff_bank: shadow coefficient register file, sync write, comb read, cleared by reset
module fir_coeff_bank
  import fir_coeff_sequencer_pkg::*;
#(
  parameter int NUM_TAPS = NUM_TAPS_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [NUM_TAPS];
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_TAPS; i++)
      if (!reset) mem[i] <= '0;
      else if (we && waddr == ADDR_W'(i)) mem[i] <= wdata;
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_TAPS; i++)
      if (raddr == ADDR_W'(i)) rdata = mem[i];
  end
endmodule

// File: rtl/fir_coeff_sequencer.sv
// fir_coeff_sequencer: stalls the sample stream and replays the shadow coefficient bank into the FIR on commit
module fir_coeff_sequencer
  import fir_coeff_sequencer_pkg::*;
#(
  parameter int NUM_TAPS = NUM_TAPS_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_commit,
  output logic              cfg_ready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] fir_tdata,
  output logic              fir_tvalid,
  output logic              fir_set_coeffs,
  output logic              load_done,
  output logic [3:0]        load_count
);
  state_t state, state_nxt;
  logic [ADDR_W-1:0] k;
  logic pending, tvalid_q, accept;
  logic [DATA_W-1:0] tdata_q, coeff;
  assign s_axis_tready = reset && state == IDLE;
  assign cfg_ready = s_axis_tready;
  assign accept = s_axis_tvalid && s_axis_tready;
  fir_coeff_bank #(.NUM_TAPS(NUM_TAPS), .DATA_W(DATA_W)) u_bank (
    .clk(clk), .reset(reset), .we(cfg_we && cfg_ready), .waddr(cfg_addr),
    .wdata(cfg_data), .raddr(k), .rdata(coeff)
  );
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? ((cfg_commit || pending) ? HOLD : IDLE)
              : state == HOLD ? LOAD
              : state == LOAD ? (k == ADDR_W'(NUM_TAPS - 1) ? DONE : LOAD)
              : (pending ? HOLD : IDLE);
    fir_set_coeffs = state == LOAD;
    load_done = state == DONE;
    fir_tvalid = tvalid_q;
    fir_tdata = state == LOAD ? coeff : tdata_q;
  end
  // pending is consumed whenever a new load begins; a commit seen outside IDLE re-arms it
  always_ff @(posedge clk)
    if (!reset) begin
      k <= '0;
      pending <= 1'b0;
      tdata_q <= '0;
      tvalid_q <= 1'b0;
      load_count <= '0;
    end else begin
      k <= state == LOAD ? k + 1'b1 : '0;
      pending <= (cfg_commit && state != IDLE) || (pending && state_nxt != HOLD);
      tvalid_q <= accept;
      if (accept) tdata_q <= s_axis_tdata;
      if (state == DONE) load_count <= load_count + 1'b1;
    end
endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// tb_fir_coeff_sequencer: directed stimulus, per-cycle check against a phase-based behavioural model
module tb_fir_coeff_sequencer;
  localparam int NT = 3;
  logic clk = 0, reset = 0, cfg_we = 0, cfg_commit = 0, s_axis_tvalid = 0;
  logic [1:0] cfg_addr = 0;
  logic [5:0] cfg_data = 0, s_axis_tdata = 0;
  logic cfg_ready, s_axis_tready, fir_tvalid, fir_set_coeffs, load_done;
  logic [5:0] fir_tdata;
  logic [3:0] load_count;
  fir_coeff_sequencer dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_ready(cfg_ready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .fir_tdata(fir_tdata),
    .fir_tvalid(fir_tvalid), .fir_set_coeffs(fir_set_coeffs), .load_done(load_done),
    .load_count(load_count)
  );
  always #5 clk = ~clk;
  int checks = 0, passes = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // Model: ph = -1 idle, 0 stall cycle, 1..NT tap ph-1 on the bus, NT+1 completion
  int ph = -1, cnt = 0;
  bit pend = 0, vld = 0, armed = 0;
  logic [5:0] last = 0;
  logic [5:0] sh [NT];
  always @(posedge clk)
    if (!reset) begin
      ph <= -1;
      pend <= 0;
      vld <= 0;
      last <= 0;
      cnt <= 0;
      for (int i = 0; i < NT; i++) sh[i] <= 0;
      armed <= 1;
    end else begin
      vld <= ph < 0 && s_axis_tvalid;
      if (ph < 0 && s_axis_tvalid) last <= s_axis_tdata;
      if (ph < 0 && cfg_we && cfg_addr < NT) sh[cfg_addr] <= cfg_data;
      if (ph == NT + 1) cnt <= (cnt + 1) % 16;
      ph <= ph < 0 ? ((cfg_commit || pend) ? 0 : -1) : ph == NT + 1 ? (pend ? 0 : -1) : ph + 1;
      pend <= (ph >= 0 && cfg_commit) ? 1'b1 : (ph < 0 || ph == NT + 1) ? 1'b0 : pend;
    end
  logic [5:0] setq[$], recvq[$];
  int ndone, nlow, nburst, last_gap, lowrun;
  bit prev_set;
  logic [5:0] td_e;
  always @(negedge clk)
    if (armed) begin
      td_e = last;
      if (ph >= 1 && ph <= NT) td_e = sh[ph-1];
      chk("tready", s_axis_tready, reset && ph < 0);
      chk("cfg_ready", cfg_ready, reset && ph < 0);
      chk("set_coeffs", fir_set_coeffs, ph >= 1 && ph <= NT);
      chk("tvalid", fir_tvalid, vld);
      chk("tdata", fir_tdata, td_e);
      chk("load_done", load_done, ph == NT + 1);
      chk("load_count", load_count, cnt);
      if (fir_set_coeffs) setq.push_back(fir_tdata);
      if (fir_tvalid) recvq.push_back(fir_tdata);
      if (load_done) ndone++;
      if (reset && !s_axis_tready) nlow++;
      if (fir_set_coeffs && !prev_set) begin
        if (nburst > 0) last_gap = lowrun;
        nburst++;
        lowrun = 0;
      end
      if (!fir_set_coeffs) lowrun++;
      prev_set = fir_set_coeffs;
    end
  task automatic clr();
    setq.delete();
    recvq.delete();
    ndone = 0;
    nlow = 0;
    nburst = 0;
    last_gap = -1;
    lowrun = 0;
  endtask
  logic [5:0] d;
  logic [5:0] sent[$];
  logic tr;
  initial begin
    step(2);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_tdata", fir_tdata, 0);
    chk("rst_tvalid", fir_tvalid, 0);
    chk("rst_set", fir_set_coeffs, 0);
    chk("rst_done", load_done, 0);
    chk("rst_count", load_count, 0);
    reset = 1;
    #1;
    chk("rel_tready", s_axis_tready, 1);
    chk("rel_cfg_ready", cfg_ready, 1);
    s_axis_tvalid = 1;
    s_axis_tdata = 6'h01;
    step;
    chk("pt_d0", fir_tdata, 6'h01);
    chk("pt_v0", fir_tvalid, 1);
    s_axis_tdata = 6'h3F;
    step;
    chk("pt_d1", fir_tdata, 6'h3F);
    s_axis_tdata = 6'h15;
    step;
    chk("pt_d2", fir_tdata, 6'h15);
    chk("pt_set", fir_set_coeffs, 0);
    s_axis_tvalid = 0;
    step;
    chk("pt_hold_d", fir_tdata, 6'h15);
    chk("pt_hold_v", fir_tvalid, 0);
    cfg_we = 1;
    cfg_addr = 0; cfg_data = 6'b000111; step;
    cfg_addr = 1; cfg_data = 6'b111011; step;
    cfg_addr = 2; cfg_data = 6'b011011; step;
    cfg_we = 0;
    clr();
    cfg_commit = 1;
    step;
    cfg_commit = 0;
    step(7);
    chk("ld_len", setq.size(), 3);
    chk("ld_t0", setq[0], 6'h07);
    chk("ld_t1", setq[1], 6'h3B);
    chk("ld_t2", setq[2], 6'h1B);
    chk("ld_bursts", nburst, 1);
    chk("ld_done_n", ndone, 1);
    chk("ld_count", load_count, 1);
    chk("ld_stall", nlow, 5);
    clr();
    sent.delete();
    d = 6'h20;
    for (int i = 0; i < 10; i++) begin
      s_axis_tvalid = 1;
      s_axis_tdata = d;
      cfg_commit = (i == 2);
      tr = s_axis_tready;
      step;
      cfg_commit = 0;
      if (tr) begin
        sent.push_back(d);
        d = d + 1'b1;
      end
      if (i == 2) begin
        chk("hold_tvalid", fir_tvalid, 1);
        chk("hold_tdata", fir_tdata, 6'h22);
        chk("hold_set", fir_set_coeffs, 0);
      end
    end
    s_axis_tvalid = 0;
    step(2);
    chk("stall_sent", sent.size(), 5);
    chk("stall_recv", recvq.size(), 5);
    for (int i = 0; i < 5; i++) chk("stall_seq", recvq[i], 6'h20 + i);
    chk("stall_count", load_count, 2);
    clr();
    cfg_commit = 1;
    step;
    cfg_commit = 0;
    step;
    cfg_commit = 1;
    cfg_we = 1;
    cfg_addr = 0;
    cfg_data = 6'h2A;
    step;
    cfg_commit = 0;
    cfg_we = 0;
    step(14);
    chk("pend_len", setq.size(), 6);
    chk("pend_t0a", setq[0], 6'h07);
    chk("pend_t0b", setq[3], 6'h07);
    chk("pend_t2b", setq[5], 6'h1B);
    chk("pend_bursts", nburst, 2);
    chk("pend_gap", last_gap, 2);
    chk("pend_done_n", ndone, 2);
    chk("pend_count", load_count, 4);
    clr();
    cfg_commit = 1;
    step;
    cfg_commit = 0;
    step(2);
    chk("ab_inload", fir_set_coeffs, 1);
    reset = 0;
    step;
    chk("ab_set", fir_set_coeffs, 0);
    chk("ab_done", load_done, 0);
    chk("ab_count", load_count, 0);
    reset = 1;
    step;
    chk("ab_nodone", ndone, 0);
    clr();
    cfg_we = 1;
    cfg_addr = 3; cfg_data = 6'h3F; step;
    cfg_addr = 1; cfg_data = 6'h11; step;
    cfg_we = 0;
    cfg_commit = 1;
    step;
    cfg_commit = 0;
    step(6);
    chk("rb_len", setq.size(), 3);
    chk("rb_t0", setq[0], 6'h00);
    chk("rb_t1", setq[1], 6'h11);
    chk("rb_t2", setq[2], 6'h00);
    chk("rb_done_n", ndone, 1);
    chk("rb_count", load_count, 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
